dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 27 ++
 rtl/dmem_host_if.sv | 99 +++++++++
 rtl/dmem_responder.sv | 91 +++++++++
 tb/tb_dmem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
// Shared definitions for the data-memory responder: host FSM state encoding,
// default memory depth and the Wishbone byte-lane merge helper.
// Optional feature macro used by the including modules: DMEM_HOST_PORT_EN.
package dmem_responder_pkg;

    typedef enum logic {
        HOST_IDLE = 1'b0,
        HOST_RESP = 1'b1
    } host_state_e;

    localparam int DMEM_DEPTH      = 256;
    localparam int DMEM_DATA_WIDTH = 32;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_word;
        for (int n = 0; n < 4; n++) begin
            if (sel[n]) merged[8*n +: 8] = new_word[8*n +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_host_if.sv
// dmem_host_if
// Wishbone-classic host port for the data memory: two-state response FSM,
// range check, write-allow gating against the core store port, and the
// registered ack/err/rdata outputs.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   cyc_i/stb_i/we_i        Wishbone cycle, strobe, write enable
//   addr_i, sel_i, wdata_i  host byte address, byte lanes, write data
//   core_write_i            core store strobe (owns the single write port)
//   mem_word_i              current memory word at idx_o
//   mem_we_o, idx_o,
//   mem_wdata_o             write request toward the array (lane-merged)
//   rdata_o, ack_o, err_o   registered Wishbone response
// Only instantiated when DMEM_HOST_PORT_EN is defined.
//
// state     | meaning
// ----------+---------------------------------------------------------
// HOST_IDLE | waiting for cyc & stb; writes held off while core stores
// HOST_RESP | ack or err high for this single cycle, then back to IDLE
module dmem_host_if
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int AW         = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [3:0]            sel_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  core_write_i,
    input  logic [DATA_WIDTH-1:0] mem_word_i,
    output logic                  mem_we_o,
    output logic [AW-1:0]         idx_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  ack_o,
    output logic                  err_o
);

    host_state_e           state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  in_range;
    logic                  start;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^addr_i[1:0];
    assign in_range        = (addr_i >> (AW + 2)) == 32'd0;
    assign idx_o           = addr_i[AW+1:2];

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        start   = 1'b0;
        case (state_q)
            HOST_IDLE: begin
                // A write must wait while the core is storing this cycle.
                if (cyc_i && stb_i && (!we_i || !core_write_i)) begin
                    start   = 1'b1;
                    state_d = HOST_RESP;
                    ack_d   = in_range;
                    err_d   = !in_range;
                    if (!in_range)  rdata_d = '0;
                    else if (!we_i) rdata_d = mem_word_i;
                end
            end
            HOST_RESP: state_d = HOST_IDLE;
            default:   state_d = HOST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= HOST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_we_o    = start && we_i && in_range;
    assign mem_wdata_o = merge_lanes(mem_word_i, wdata_i, sel_i);
    assign rdata_o     = rdata_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Flop-based data memory for the Osiris I M stage. Core reads are
// combinational, core stores commit on the clock edge; out-of-range
// accesses read zero and stores to them are dropped.
// With DMEM_HOST_PORT_EN defined a Wishbone-classic host port (dmem_host_if)
// can preload/inspect memory; otherwise host inputs are ignored and the
// host outputs are tied to zero.
// Ports:
//   clk, rst                        clock, async active-high reset
//   i_data_addr_M, i_write_data_M,
//   i_mem_write_M, o_read_data_M    core memory-stage port
//   i_host_*, o_host_*              Wishbone host port
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int DEPTH      = DMEM_DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           i_data_addr_M,
    input  logic [DATA_WIDTH-1:0] i_write_data_M,
    input  logic                  i_mem_write_M,
    output logic [DATA_WIDTH-1:0] o_read_data_M,
    input  logic                  i_host_cyc,
    input  logic                  i_host_stb,
    input  logic                  i_host_we,
    input  logic [31:0]           i_host_addr,
    input  logic [3:0]            i_host_sel,
    input  logic [DATA_WIDTH-1:0] i_host_wdata,
    output logic [DATA_WIDTH-1:0] o_host_rdata,
    output logic                  o_host_ack,
    output logic                  o_host_err
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         core_idx;
    logic                  core_in_range;
    logic                  host_we;
    logic [AW-1:0]         host_idx;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  unused_core_lsb;

    assign unused_core_lsb = ^i_data_addr_M[1:0];
    assign core_idx        = i_data_addr_M[AW+1:2];
    assign core_in_range   = (i_data_addr_M >> (AW + 2)) == 32'd0;
    assign o_read_data_M   = core_in_range ? mem_q[core_idx] : '0;

`ifdef DMEM_HOST_PORT_EN
    dmem_host_if #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_host_if (
        .clk_i        (clk),
        .rst_i        (rst),
        .cyc_i        (i_host_cyc),
        .stb_i        (i_host_stb),
        .we_i         (i_host_we),
        .addr_i       (i_host_addr),
        .sel_i        (i_host_sel),
        .wdata_i      (i_host_wdata),
        .core_write_i (i_mem_write_M),
        .mem_word_i   (mem_q[host_idx]),
        .mem_we_o     (host_we),
        .idx_o        (host_idx),
        .mem_wdata_o  (host_wdata),
        .rdata_o      (o_host_rdata),
        .ack_o        (o_host_ack),
        .err_o        (o_host_err)
    );
`else
    logic unused_host;
    assign unused_host  = ^{i_host_cyc, i_host_stb, i_host_we, i_host_addr,
                            i_host_sel, i_host_wdata, host_idx, host_wdata};
    assign host_we      = 1'b0;
    assign host_idx     = '0;
    assign host_wdata   = '0;
    assign o_host_rdata = '0;
    assign o_host_ack   = 1'b0;
    assign o_host_err   = 1'b0;
`endif

    // Contents are intentionally not reset. The host FSM never asserts
    // host_we while the core is storing, so the two writes cannot collide.
    always_ff @(posedge clk) begin
        if (i_mem_write_M && core_in_range) mem_q[core_idx] <= i_write_data_M;
        if (host_we)                        mem_q[host_idx] <= host_wdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_data_addr_M;
    logic [31:0] i_write_data_M;
    logic        i_mem_write_M;
    logic [31:0] o_read_data_M;
    logic        i_host_cyc;
    logic        i_host_stb;
    logic        i_host_we;
    logic [31:0] i_host_addr;
    logic [3:0]  i_host_sel;
    logic [31:0] i_host_wdata;
    logic [31:0] o_host_rdata;
    logic        o_host_ack;
    logic        o_host_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .i_data_addr_M  (i_data_addr_M),
        .i_write_data_M (i_write_data_M),
        .i_mem_write_M  (i_mem_write_M),
        .o_read_data_M  (o_read_data_M),
        .i_host_cyc     (i_host_cyc),
        .i_host_stb     (i_host_stb),
        .i_host_we      (i_host_we),
        .i_host_addr    (i_host_addr),
        .i_host_sel     (i_host_sel),
        .i_host_wdata   (i_host_wdata),
        .o_host_rdata   (o_host_rdata),
        .o_host_ack     (o_host_ack),
        .o_host_err     (o_host_err)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } core_vec_t;

    core_vec_t vecs[14];

    task automatic core_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        @(negedge clk);
        i_mem_write_M = 1'b0;
        i_data_addr_M = addr;
        #1;
        check32(name, o_read_data_M, exp);
    endtask

`ifdef DMEM_HOST_PORT_EN
    // Runs one host transfer; lat is the number of edges until ack/err seen
    // (0 on timeout), nxt captures {ack,err} one cycle after the response.
    task automatic host_xfer(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] wdata, output int lat, output logic ack,
                             output logic err, output logic [31:0] rdata, output logic [1:0] nxt);
        @(negedge clk);
        i_host_cyc = 1'b1; i_host_stb = 1'b1; i_host_we = we;
        i_host_addr = addr; i_host_sel = sel; i_host_wdata = wdata;
        lat = 0; ack = 1'b0; err = 1'b0; rdata = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (o_host_ack || o_host_err) begin
                lat = c; ack = o_host_ack; err = o_host_err; rdata = o_host_rdata;
                break;
            end
        end
        i_host_cyc = 1'b0; i_host_stb = 1'b0; i_host_we = 1'b0;
        @(posedge clk); #1;
        nxt = {o_host_ack, o_host_err};
    endtask
`endif

    initial begin
        int          lat;
        logic        ack, err;
        logic [31:0] rdata;
        logic [1:0]  nxt;

        rst = 1'b1;
        i_data_addr_M = '0; i_write_data_M = '0; i_mem_write_M = 1'b0;
        i_host_cyc = 1'b0; i_host_stb = 1'b0; i_host_we = 1'b0;
        i_host_addr = '0; i_host_sel = '0; i_host_wdata = '0;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'h0102_0304, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0102_0304};
        vecs[5]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[6]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0102_0304};
        vecs[8]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, 32'h0000_0010, 32'h55AA_55AA, 1'b1, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h55AA_55AA};
        vecs[11] = '{1'b0, 32'h8000_0010, 32'h0,         1'b1, 32'h0};
        vecs[12] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0102_0304};

        repeat (2) @(posedge clk);
        #1;
        check32("reset_ack", {31'd0, o_host_ack}, 32'd0);
        check32("reset_err", {31'd0, o_host_err}, 32'd0);
        check32("reset_rdata", o_host_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            i_mem_write_M  = vecs[i].we;
            i_data_addr_M  = vecs[i].addr;
            i_write_data_M = vecs[i].wdata;
            #1;
            if (vecs[i].chk) check32($sformatf("core_vec%0d", i), o_read_data_M, vecs[i].exp);
        end
        @(negedge clk);
        i_mem_write_M = 1'b0;

`ifdef DMEM_HOST_PORT_EN
        // Byte-lane write over a known word, then read it back by both ports.
        @(negedge clk);
        i_mem_write_M = 1'b1; i_data_addr_M = 32'h20; i_write_data_M = 32'hAAAA_AAAA;
        @(negedge clk);
        i_mem_write_M = 1'b0;
        host_xfer(1'b1, 32'h20, 4'b0101, 32'h1122_3344, lat, ack, err, rdata, nxt);
        check32("hw_lat", lat, 1);
        check32("hw_ackerr", {30'd0, ack, err}, 32'd2);
        check32("hw_next", {30'd0, nxt}, 32'd0);
        core_read(32'h20, 32'hAA22_AA44, "hw_core_rd");
        host_xfer(1'b0, 32'h20, 4'b0000, 32'h0, lat, ack, err, rdata, nxt);
        check32("hr_lat", lat, 1);
        check32("hr_ackerr", {30'd0, ack, err}, 32'd2);
        check32("hr_rdata", rdata, 32'hAA22_AA44);

        // Host write held off by three cycles of core stores to the same word.
        @(negedge clk);
        i_mem_write_M = 1'b1; i_data_addr_M = 32'h30; i_write_data_M = 32'h9988_7766;
        i_host_cyc = 1'b1; i_host_stb = 1'b1; i_host_we = 1'b1;
        i_host_addr = 32'h30; i_host_sel = 4'b1000; i_host_wdata = 32'h1100_0000;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check32($sformatf("blk_ack%0d", k), {30'd0, o_host_ack, o_host_err}, 32'd0);
        end
        @(negedge clk);
        i_mem_write_M = 1'b0;
        @(posedge clk); #1;
        check32("blk_ack4", {30'd0, o_host_ack, o_host_err}, 32'd2);
        i_host_cyc = 1'b0; i_host_stb = 1'b0; i_host_we = 1'b0;
        core_read(32'h30, 32'h1188_7766, "blk_merged");

        // Host read and core write of the same word on one edge: old value.
        @(negedge clk);
        i_mem_write_M = 1'b1; i_data_addr_M = 32'h10; i_write_data_M = 32'h0BAD_F00D;
        i_host_cyc = 1'b1; i_host_stb = 1'b1; i_host_we = 1'b0; i_host_addr = 32'h10;
        @(posedge clk); #1;
        check32("same_edge_ack", {31'd0, o_host_ack}, 32'd1);
        check32("same_edge_old", o_host_rdata, 32'h55AA_55AA);
        i_host_cyc = 1'b0; i_host_stb = 1'b0;
        core_read(32'h10, 32'h0BAD_F00D, "same_edge_core");

        // Out-of-range host accesses.
        host_xfer(1'b0, 32'h8000, 4'b0000, 32'h0, lat, ack, err, rdata, nxt);
        check32("oor_rd_lat", lat, 1);
        check32("oor_rd_ackerr", {30'd0, ack, err}, 32'd1);
        check32("oor_rd_rdata", rdata, 32'd0);
        check32("oor_rd_next", {30'd0, nxt}, 32'd0);
        host_xfer(1'b1, 32'h8000, 4'b1111, 32'hFFFF_FFFF, lat, ack, err, rdata, nxt);
        check32("oor_wr_ackerr", {30'd0, ack, err}, 32'd1);
        core_read(32'h0, 32'h0102_0304, "oor_mem_kept");

        // Reset while a response is being presented.
        @(negedge clk);
        i_host_cyc = 1'b1; i_host_stb = 1'b1; i_host_we = 1'b0; i_host_addr = 32'h20;
        @(posedge clk); #1;
        check32("pre_rst_ack", {31'd0, o_host_ack}, 32'd1);
        rst = 1'b1;
        #1;
        check32("rst_mid_ack", {31'd0, o_host_ack}, 32'd0);
        check32("rst_mid_err", {31'd0, o_host_err}, 32'd0);
        check32("rst_mid_rdata", o_host_rdata, 32'd0);
        i_host_cyc = 1'b0; i_host_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        host_xfer(1'b0, 32'h20, 4'b0000, 32'h0, lat, ack, err, rdata, nxt);
        check32("post_rst_lat", lat, 1);
        check32("post_rst_rdata", rdata, 32'hAA22_AA44);
`else
        // Host port compiled out: strobes must have no effect anywhere.
        @(negedge clk);
        i_host_cyc = 1'b1; i_host_stb = 1'b1; i_host_we = 1'b1;
        i_host_addr = 32'h10; i_host_sel = 4'hF; i_host_wdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check32($sformatf("nohost_resp%0d", k), {o_host_rdata[29:0], o_host_ack, o_host_err}, 32'd0);
            check32($sformatf("nohost_rdhi%0d", k), {30'd0, o_host_rdata[31:30]}, 32'd0);
        end
        i_host_cyc = 1'b0; i_host_stb = 1'b0; i_host_we = 1'b0;
        core_read(32'h10, 32'h55AA_55AA, "nohost_mem_kept");
        @(negedge clk);
        i_mem_write_M = 1'b1; i_data_addr_M = 32'h14; i_write_data_M = 32'h7777_0001;
        core_read(32'h14, 32'h7777_0001, "nohost_core_wr");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
